// File: rtl/alu4_pkg.sv
// Shared opcode encodings for the alu4_dec_enc datapath bundle.
package alu4_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

endpackage

// File: rtl/alu4_core.sv
// Purely combinational ALU: result plus zero, signed-overflow and carry flags.
module alu4_core
  import alu4_pkg::*;
#(
  parameter int unsigned ALU_W = 4
) (
  input  logic [2:0]       fn_i,
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  output logic [ALU_W-1:0] res_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             carry_o
);

  localparam int unsigned Msb = ALU_W - 1;

  logic [ALU_W:0] add_full;
  logic [ALU_W:0] sub_full;
  logic           add_ovf;
  logic           sub_ovf;

  assign add_full = {1'b0, a_i} + {1'b0, b_i};
  // Subtract as A + ~B + 1 so the top bit is the "no borrow" carry.
  assign sub_full = {1'b0, a_i} + {1'b0, ~b_i} + {{ALU_W{1'b0}}, 1'b1};

  assign add_ovf = (a_i[Msb] == b_i[Msb]) && (add_full[Msb] != a_i[Msb]);
  assign sub_ovf = (a_i[Msb] != b_i[Msb]) && (sub_full[Msb] != a_i[Msb]);

  always_comb begin
    res_o   = '0;
    ovf_o   = 1'b0;
    carry_o = 1'b0;
    unique case (fn_i)
      OP_ADD: begin
        res_o   = add_full[ALU_W-1:0];
        ovf_o   = add_ovf;
        carry_o = add_full[ALU_W];
      end
      OP_SUB: begin
        res_o   = sub_full[ALU_W-1:0];
        ovf_o   = sub_ovf;
        carry_o = sub_full[ALU_W];
      end
      OP_NOT: res_o = ~a_i;
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_XOR: res_o = a_i ^ b_i;
      OP_LT:  res_o = {{(ALU_W-1){1'b0}}, sub_full[Msb] ^ sub_ovf};
      OP_EQ:  res_o = {{(ALU_W-1){1'b0}}, a_i == b_i};
      default: res_o = '0;
    endcase
  end

  assign zero_o = (res_o == '0);

endmodule

// File: rtl/alu4_dec_enc.sv
// Registered ALU, 3-to-8 decoder and 8-to-3 priority encoder lanes.
// Define ENC_VALID_EN to add the enc_valid output.
module alu4_dec_enc
  import alu4_pkg::*;
#(
  parameter int unsigned ALU_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [2:0]       alu_fnselec,
  input  logic [ALU_W-1:0] alu_a,
  input  logic [ALU_W-1:0] alu_b,
  output logic [ALU_W-1:0] alu_res,
  output logic             alu_zero,
  output logic             alu_overflow,
  output logic             alu_carry,
  input  logic [2:0]       dec_x,
  input  logic             dec_en,
  output logic [7:0]       dec_y,
  input  logic [7:0]       enc_x,
  input  logic             enc_en,
`ifdef ENC_VALID_EN
  output logic             enc_valid,
`endif
  output logic [2:0]       enc_y
);

  logic [ALU_W-1:0] res_d, res_q;
  logic             zero_d, zero_q;
  logic             ovf_d, ovf_q;
  logic             carry_d, carry_q;
  logic [7:0]       dec_d, dec_q;
  logic [2:0]       enc_d, enc_q;

  alu4_core #(
    .ALU_W (ALU_W)
  ) u_alu4_core (
    .fn_i    (alu_fnselec),
    .a_i     (alu_a),
    .b_i     (alu_b),
    .res_o   (res_d),
    .zero_o  (zero_d),
    .ovf_o   (ovf_d),
    .carry_o (carry_d)
  );

  assign dec_d = dec_en ? (8'b1 << dec_x) : 8'b0;

  // Ascending scan: the highest set bit is the last to write.
  always_comb begin
    enc_d = 3'b000;
    if (enc_en) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (enc_x[i]) enc_d = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
      dec_q   <= '0;
      enc_q   <= '0;
    end else begin
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
      dec_q   <= dec_d;
      enc_q   <= enc_d;
    end
  end

  assign alu_res      = res_q;
  assign alu_zero     = zero_q;
  assign alu_overflow = ovf_q;
  assign alu_carry    = carry_q;
  assign dec_y        = dec_q;
  assign enc_y        = enc_q;

`ifdef ENC_VALID_EN
  logic valid_d, valid_q;

  assign valid_d = enc_en & (|enc_x);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) valid_q <= 1'b0;
    else         valid_q <= valid_d;
  end

  assign enc_valid = valid_q;
`endif

endmodule

// File: tb/tb_alu4_dec_enc.sv
// Self-checking bench for alu4_dec_enc: vector table, random model vectors, reset corner.
module tb_alu4_dec_enc;

  typedef struct {
    logic [2:0] fn;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] dx;
    logic       de;
    logic [7:0] ex;
    logic       ee;
    logic [3:0] res;
    logic       z;
    logic       v;
    logic       c;
    logic [7:0] dy;
    logic [2:0] ey;
    logic       ev;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] alu_fnselec = '0;
  logic [3:0] alu_a = '0;
  logic [3:0] alu_b = '0;
  logic [3:0] alu_res;
  logic       alu_zero, alu_overflow, alu_carry;
  logic [2:0] dec_x = '0;
  logic       dec_en = 1'b0;
  logic [7:0] dec_y;
  logic [7:0] enc_x = '0;
  logic       enc_en = 1'b0;
  logic [2:0] enc_y;
`ifdef ENC_VALID_EN
  logic       enc_valid;
`endif

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  alu4_dec_enc #(
    .ALU_W (4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .alu_fnselec  (alu_fnselec),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_res      (alu_res),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .dec_x        (dec_x),
    .dec_en       (dec_en),
    .dec_y        (dec_y),
    .enc_x        (enc_x),
    .enc_en       (enc_en),
`ifdef ENC_VALID_EN
    .enc_valid    (enc_valid),
`endif
    .enc_y        (enc_y)
  );

  function automatic vec_t mk(logic [2:0] fn, logic [3:0] a, logic [3:0] b, logic [2:0] dx,
                              logic de, logic [7:0] ex, logic ee, logic [3:0] res, logic z,
                              logic v, logic c, logic [7:0] dy, logic [2:0] ey, logic ev);
    vec_t t;
    t.fn = fn; t.a = a; t.b = b; t.dx = dx; t.de = de; t.ex = ex; t.ee = ee;
    t.res = res; t.z = z; t.v = v; t.c = c; t.dy = dy; t.ey = ey; t.ev = ev;
    return t;
  endfunction

  // Integer-arithmetic reference for random vectors.
  function automatic vec_t model(vec_t t);
    int ua, ub, sa, sb_, r, s;
    ua = int'(t.a);
    ub = int'(t.b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb_ = (ub >= 8) ? ub - 16 : ub;
    t.v = 1'b0;
    t.c = 1'b0;
    case (t.fn)
      3'd0: begin
        r = ua + ub; s = sa + sb_;
        t.res = 4'(r % 16); t.c = (r >= 16); t.v = (s > 7) || (s < -8);
      end
      3'd1: begin
        r = ua - ub; s = sa - sb_;
        t.res = 4'((r + 16) % 16); t.c = (ua >= ub); t.v = (s > 7) || (s < -8);
      end
      3'd2: t.res = ~t.a;
      3'd3: t.res = t.a & t.b;
      3'd4: t.res = t.a | t.b;
      3'd5: t.res = t.a ^ t.b;
      3'd6: t.res = (sa < sb_) ? 4'd1 : 4'd0;
      default: t.res = (ua == ub) ? 4'd1 : 4'd0;
    endcase
    t.z = (t.res == 4'd0);
    for (int i = 0; i < 8; i++) t.dy[i] = t.de && (int'(t.dx) == i);
    t.ey = 3'd0;
    t.ev = 1'b0;
    if (t.ee) begin
      for (int i = 7; i >= 0; i--) begin
        if (t.ex[i] && !t.ev) begin
          t.ey = 3'(i);
          t.ev = 1'b1;
        end
      end
    end
    return t;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_out(vec_t e, string tag);
    chk({tag, ".res"},   {4'b0, alu_res},      {4'b0, e.res});
    chk({tag, ".zero"},  {7'b0, alu_zero},     {7'b0, e.z});
    chk({tag, ".ovf"},   {7'b0, alu_overflow}, {7'b0, e.v});
    chk({tag, ".carry"}, {7'b0, alu_carry},    {7'b0, e.c});
    chk({tag, ".dec_y"}, dec_y,                e.dy);
    chk({tag, ".enc_y"}, {5'b0, enc_y},        {5'b0, e.ey});
`ifdef ENC_VALID_EN
    chk({tag, ".enc_valid"}, {7'b0, enc_valid}, {7'b0, e.ev});
`endif
  endtask

  task automatic drive(vec_t t);
    alu_fnselec = t.fn; alu_a = t.a; alu_b = t.b;
    dec_x = t.dx; dec_en = t.de; enc_x = t.ex; enc_en = t.ee;
    sb.push_back(t);
  endtask

  task automatic run_one(vec_t t, string tag);
    vec_t e;
    @(negedge clk);
    drive(t);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      compare_out(e, tag);
    end
  endtask

  initial begin
    vec_t zv, t, hold;
    zv = mk(3'd0, 4'd0, 4'd0, 3'd0, 1'b0, 8'd0, 1'b0,
            4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0);

    //        fn    a        b        dx    de  ex            ee  res      z  v  c  dy            ey    ev
    tbl.push_back(mk(3'd0, 4'b0111, 4'b0001, 3'd5, 1, 8'b0100_1010, 1, 4'b1000, 0, 1, 0, 8'b0010_0000, 3'd6, 1));
    tbl.push_back(mk(3'd0, 4'b1111, 4'b0001, 3'd5, 0, 8'b0000_0000, 1, 4'b0000, 1, 0, 1, 8'b0000_0000, 3'd0, 0));
    tbl.push_back(mk(3'd1, 4'b0011, 4'b0101, 3'd0, 1, 8'b0000_0001, 1, 4'b1110, 0, 0, 0, 8'b0000_0001, 3'd0, 1));
    tbl.push_back(mk(3'd6, 4'b1000, 4'b0111, 3'd7, 1, 8'b1000_0000, 0, 4'b0001, 0, 0, 0, 8'b1000_0000, 3'd0, 0));
    tbl.push_back(mk(3'd7, 4'b0101, 4'b0101, 3'd3, 1, 8'b1111_1111, 1, 4'b0001, 0, 0, 0, 8'b0000_1000, 3'd7, 1));
    tbl.push_back(mk(3'd2, 4'b1010, 4'b0000, 3'd2, 0, 8'b0000_0110, 1, 4'b0101, 0, 0, 0, 8'b0000_0000, 3'd2, 1));
    tbl.push_back(mk(3'd3, 4'b1100, 4'b1010, 3'd1, 1, 8'b0001_0000, 1, 4'b1000, 0, 0, 0, 8'b0000_0010, 3'd4, 1));
    tbl.push_back(mk(3'd5, 4'b1100, 4'b1100, 3'd4, 1, 8'b0000_0000, 0, 4'b0000, 1, 0, 0, 8'b0001_0000, 3'd0, 0));
    tbl.push_back(mk(3'd4, 4'b0000, 4'b0000, 3'd6, 1, 8'b0010_0011, 1, 4'b0000, 1, 0, 0, 8'b0100_0000, 3'd5, 1));
    tbl.push_back(mk(3'd1, 4'b0101, 4'b0101, 3'd0, 0, 8'b0000_0010, 1, 4'b0000, 1, 0, 1, 8'b0000_0000, 3'd1, 1));
    tbl.push_back(mk(3'd1, 4'b1000, 4'b0001, 3'd0, 0, 8'b0000_0000, 0, 4'b0111, 0, 1, 1, 8'b0000_0000, 3'd0, 0));
    tbl.push_back(mk(3'd6, 4'b0111, 4'b1000, 3'd0, 0, 8'b0000_0000, 0, 4'b0000, 1, 0, 0, 8'b0000_0000, 3'd0, 0));
    tbl.push_back(mk(3'd7, 4'b0101, 4'b0100, 3'd0, 0, 8'b0000_0000, 0, 4'b0000, 1, 0, 0, 8'b0000_0000, 3'd0, 0));

    // Reset state, before any clock edge
    #2;
    compare_out(zv, "reset");
    @(negedge clk);
    resetn = 1'b1;

    foreach (tbl[i]) run_one(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      t = zv;
      t.fn = 3'($urandom_range(0, 7));
      t.a  = 4'($urandom_range(0, 15));
      t.b  = 4'($urandom_range(0, 15));
      t.dx = 3'($urandom_range(0, 7));
      t.de = 1'($urandom_range(0, 1));
      t.ex = 8'($urandom_range(0, 255));
      t.ee = 1'($urandom_range(0, 1));
      run_one(model(t), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-cycle clears outputs without waiting for an edge
    hold = tbl[0];
    run_one(hold, "pre_rst");
    #2;
    resetn = 1'b0;
    #1;
    compare_out(zv, "async_rst");
    #1;
    resetn = 1'b1;
    #1;
    compare_out(zv, "post_release");
    @(posedge clk);
    #1;
    compare_out(hold, "first_edge");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
